// File: rtl/timer_arbiter_defs.sv
// -----------------------------------------------------------------------------
// timer_arbiter_defs
// Shared definitions for the timer arbiter:
//   - FSM state encodings (IDLE, COUNT, ACK)
//   - requester identifiers (A = 0, B = 1)
//   - pick_winner(): round-robin choice between the two requesters
// -----------------------------------------------------------------------------
package timer_arbiter_defs;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        COUNT = ST_COUNT,
        ACK   = ST_ACK
    } state_t;

    // On a tie the requester that was not served last wins; otherwise the
    // single active requester wins. Only meaningful when at least one
    // request is present.
    function automatic logic pick_winner(input logic req_a,
                                         input logic req_b,
                                         input logic last);
        if (req_a && req_b)
            return (last == REQ_B) ? REQ_A : REQ_B;
        else if (req_a)
            return REQ_A;
        else
            return REQ_B;
    endfunction

endpackage

// File: rtl/timer_arbiter_countdown.sv
// -----------------------------------------------------------------------------
// countdown
// Loadable down-counter that saturates at zero.
// Ports:
//   clock      - clock, all state changes on posedge
//   reset_     - synchronous active-low reset (counter cleared to 0)
//   load       - load load_value into the counter (has priority over enable)
//   load_value - value to load
//   enable     - decrement by one when nonzero
//   zero       - counter currently holds 0
// -----------------------------------------------------------------------------
module countdown #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_)
            cnt <= '0;
        else if (load)
            cnt <= load_value;
        else if (enable && (cnt != '0))
            cnt <= cnt - 1'b1;   // never wraps below zero
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
// Two requesters share one countdown timer through a 4-phase handshake
// (req up -> ack up -> req down -> ack down). Ties are resolved round-robin.
// Ports:
//   clock         - clock, all state changes on posedge
//   reset_        - synchronous active-low reset
//   req_a / req_b - request a timed wait
//   dly_a / dly_b - delay count, sampled only at grant
//   ack_a / ack_b - registered: owner's wait has expired
//   busy          - registered: FSM is not in IDLE
// A grant at edge k with delay N raises the owner's ack at edge k+N+1.
// -----------------------------------------------------------------------------
module timer_arbiter
    import timer_arbiter_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             req_a,
    input  logic [WIDTH-1:0] dly_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] dly_b,
    output logic             ack_b,
    output logic             busy
);

    state_t           state, state_next;
    logic             owner, owner_next;
    logic             last, last_next;
    logic             ack_a_next, ack_b_next, busy_next;
    logic             grant;
    logic             req_owner;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_value;
    logic             cnt_enable;
    logic             cnt_zero;

    countdown #(.WIDTH(WIDTH)) u_countdown (
        .clock      (clock),
        .reset_     (reset_),
        .load       (cnt_load),
        .load_value (cnt_value),
        .enable     (cnt_enable),
        .zero       (cnt_zero)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        cnt_load   = 1'b0;
        cnt_value  = dly_a;
        grant      = pick_winner(req_a, req_b, last);
        req_owner  = (owner == REQ_A) ? req_a : req_b;

        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    owner_next = grant;
                    cnt_load   = 1'b1;
                    cnt_value  = (grant == REQ_A) ? dly_a : dly_b;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                // Counter decrements on its own while enabled; leave once it
                // has been observed at zero, even if req_owner dropped early.
                if (cnt_zero)
                    state_next = ACK;
            end
            ACK: begin
                if (!req_owner) begin
                    state_next = IDLE;
                    last_next  = owner;
                end
            end
            default: state_next = IDLE;
        endcase

        cnt_enable = (state == COUNT);

        // Outputs are registered from the next state so they line up with it.
        ack_a_next = (state_next == ACK) && (owner_next == REQ_A);
        ack_b_next = (state_next == ACK) && (owner_next == REQ_B);
        busy_next  = (state_next != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state <= IDLE;
            owner <= REQ_A;
            last  <= REQ_B;
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            last  <= last_next;
            ack_a <= ack_a_next;
            ack_b <= ack_b_next;
            busy  <= busy_next;
        end
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the width of the delay operand and countdown counter.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its posedge.
REQ-003 The block SHALL have port reset_, input, 1, the reset: synchronous and active-low.
REQ-004 The block SHALL have port req_a, input, 1, the request from requester A for one timed wait.
REQ-005 The block SHALL have port dly_a, input, WIDTH, requester A's delay count, valid while req_a=1.
REQ-006 The block SHALL have port ack_a, output, 1, asserted when A's wait has expired.
REQ-007 The block SHALL have port req_b, input, 1, the request from requester B.
REQ-008 The block SHALL have port dly_b, input, WIDTH, requester B's delay count.
REQ-009 The block SHALL have port ack_b, output, 1, asserted when B's wait has expired.
REQ-010 The block SHALL have port busy, output, 1, equal to 1 in any state other than IDLE.

Function
REQ-011 The block SHALL share one WIDTH-bit countdown counter (CNT) between A and B, using a 4-phase handshake: req up -> ack up -> req down -> ack down.
REQ-012 The block SHALL implement states IDLE, COUNT and ACK; ack_x and busy SHALL be registered outputs.
REQ-013 In IDLE with no request pending, the block SHALL stay in IDLE with all outputs 0.
REQ-014 In IDLE with exactly one request pending, at the next edge the block SHALL set OWNER to that requester, set CNT to its dly and enter COUNT.
REQ-015 In IDLE with both requests pending, the block SHALL grant the requester not served last (LAST flag); after reset LAST=B, so A wins the first tie.
REQ-016 In COUNT, if CNT≠0 the block SHALL decrement CNT and stay; if CNT=0 it SHALL enter ACK and raise ack_OWNER at that edge.
REQ-017 Latency: for a grant at edge k with dly=N, ack SHALL rise at edge k+N+1 (N=0 gives k+1; N=2^WIDTH-1 gives k+2^WIDTH); CNT never wraps.
REQ-018 In ACK, ack_OWNER SHALL stay 1 until req_OWNER is sampled 0; at that edge the block SHALL drop ack, set LAST=OWNER and return to IDLE.
REQ-019 The block SHALL never assert ack_a and ack_b together, and never assert an ack for a non-owner.
REQ-020 Requests arriving while busy SHALL wait unserved; the non-owner's req/dly SHALL be ignored until IDLE.
REQ-021 The block SHALL sample dly only at grant, so dly changes during COUNT SHALL have no effect.
REQ-022 If req_OWNER drops during COUNT (protocol violation), the block SHALL complete the count and the ACK phase normally; ACK then exits at the next edge.
REQ-023 The block SHALL need at least one IDLE cycle between consecutive grants, including back-to-back requests from the same requester.

Reset
REQ-024 When reset_=0 at a posedge, the block SHALL set state=IDLE, CNT=0, OWNER=A, LAST=B and ack_a=ack_b=busy=0, regardless of state.
REQ-025 Reset during COUNT or ACK SHALL abandon the operation with no ack; the requester must re-request.
REQ-026 While reset_=0, the block SHALL ignore all requests.

Structure
REQ-027 State encodings (IDLE, COUNT, ACK) and the requester IDs (A=0, B=1) SHALL be localparams in a shared include file, timer_arbiter_defs.
REQ-028 The counter SHALL be one sub-module, countdown (inputs load, load value, enable; output zero), instantiated once.
REQ-029 Arbitration and the handshake FSM SHALL remain in timer_arbiter.

Verification
REQ-030 The bench SHALL cover: reset, then req_a=1 with dly_a=3 at edge 0 -> grant at edge 1, ack_a=1 at edge 5; drop req_a -> ack_a=0 at the next edge, busy=0.
REQ-031 The bench SHALL cover: req_a and req_b raised together (dly 0 and 5) from reset -> A served first (ack_a at grant+1), then B granted after one IDLE cycle, ack_b at its grant+6.
REQ-032 The bench SHALL cover: after A is served, both requesting again -> B wins (round-robin); two further ties alternate A, B.
REQ-033 The bench SHALL cover: dly_b=255 with WIDTH=8 -> ack_b exactly 256 cycles after grant, with no wrap or early ack.
REQ-034 The bench SHALL cover: reset_=0 for one cycle mid-COUNT -> next edge busy=0, acks 0; with req still high, a fresh grant with CNT reloaded.
REQ-035 The bench SHALL cover: dly_a changed during COUNT, and req_b held throughout -> A's latency unchanged, ack_b never asserted before A's ACK exits.
